ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 32, giving the ALU result, store data and PC width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, giving the destination register address width.
REQ-003 SHALL have ports (clock and reset first): clk_i  in  1  single clock; rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 flush_i  in  1  discard all held and incoming entries.
REQ-005 up_valid_i  in  1  execute stage presents an entry; up_ready_o  out  1  stage can accept.
REQ-006 alu_out_i  in  DAT_WIDTH  ALU result; alu_of_i  in  1  ALU overflow flag; ovf_chk_i  in  1  instruction is signed add/sub (overflow traps).
REQ-007 wr_en_i  in  1  register writeback request; wr_addr_i  in  REG_ADDR_W  destination register.
REQ-008 mem_op_i  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none); store_dat_i  in  DAT_WIDTH; pc_i  in  DAT_WIDTH.
REQ-009 dn_valid_o  out  1  entry valid to memory stage; dn_ready_i  in  1  memory stage accepts.
REQ-010 alu_out_o, store_dat_o, pc_o  out  DAT_WIDTH; wr_en_o  out  1; wr_addr_o  out  REG_ADDR_W; mem_op_o  out  2: head-entry fields.
REQ-011 exc_o  out  1  one-cycle overflow exception pulse; exc_pc_o  out  DAT_WIDTH  PC of trapping instruction.

Function
REQ-012 Upstream transfer SHALL occur on a cycle with up_valid_i && up_ready_o; downstream transfer on dn_valid_o && dn_ready_i.
REQ-013 Entries SHALL leave in acceptance order; no entry dropped or duplicated except by flush_i.
REQ-014 Latency SHALL be one cycle: an entry accepted in cycle N with the stage empty is presented on dn_valid_o in cycle N+1.
REQ-015 Head-entry outputs SHALL hold stable while dn_valid_o && !dn_ready_i.
REQ-016 On acceptance with alu_of_i && ovf_chk_i, the entry SHALL be stored with wr_en forced 0, mem_op forced 00, and an internal exception flag set.
REQ-017 alu_of_i with ovf_chk_i=0 (unsigned ops) SHALL be ignored.
REQ-018 When an entry carrying the exception flag completes a downstream transfer, exc_o SHALL be 1 in the following cycle only, with exc_pc_o equal to that entry's pc; otherwise exc_o=0 and exc_pc_o holds its last value.
REQ-019 mem_op_i=11 SHALL be stored as 00.
REQ-020 Simultaneous upstream and downstream transfer while one entry is held SHALL replace the head with the new entry and keep occupancy unchanged.
REQ-021 flush_i SHALL take priority: next cycle all entries are invalid, dn_valid_o=0, and any same-cycle upstream entry is discarded; a pending exc_o pulse from a same-cycle downstream transfer SHALL still be issued.
REQ-022 Data fields of invalid entries SHALL be don't-care; only dn_valid_o and exc_o are qualified.

Reset
REQ-023 While rst_n_i=0, all entries SHALL be invalid, and dn_valid_o=0, exc_o=0, wr_en_o=0, mem_op_o=00.
REQ-024 alu_out_o, store_dat_o, pc_o, wr_addr_o, exc_pc_o SHALL reset to 0.
REQ-025 up_ready_o SHALL be 1 in the first cycle after reset release.
REQ-026 Reset asserted mid-transfer SHALL discard all entries and any pending exc_o pulse.

Configuration
REQ-027 Macro EX_MEM_SKID_EN defined: two-entry storage (head + skid); up_ready_o SHALL be a registered signal equal to "skid entry empty", with no combinational path from dn_ready_i.
REQ-028 With EX_MEM_SKID_EN, an entry accepted while the head stalls SHALL go to the skid entry and move to the head on the next downstream transfer; a full stage (2 entries) SHALL deassert up_ready_o.
REQ-029 EX_MEM_SKID_EN undefined: single entry; up_ready_o SHALL equal !dn_valid_o || dn_ready_i combinationally.
REQ-030 All REQs except 027-029 SHALL hold in both configurations.

Verification
REQ-031 Accept alu_out_i=0x0000_0005, wr_en_i=1, wr_addr_i=3, dn_ready_i=1 -> next cycle dn_valid_o=1, alu_out_o=5, wr_addr_o=3, then dn_valid_o=0.
REQ-032 ovf_chk_i=1, alu_of_i=1, pc_i=0x0000_0100, wr_en_i=1, mem_op_i=01 -> wr_en_o=0, mem_op_o=00; one cycle after downstream transfer exc_o=1 for exactly one cycle, exc_pc_o=0x100.
REQ-033 alu_of_i=1, ovf_chk_i=0 -> exc_o stays 0, wr_en_o follows wr_en_i.
REQ-034 dn_ready_i=0 for 4 cycles with up_valid_i=1 and values 1,2,3 -> SKID_EN: two accepted, up_ready_o=0 from third cycle, order 1,2 on release; no SKID_EN: one accepted, output held at 1.
REQ-035 flush_i=1 with two entries held and up_valid_i=1 -> next cycle dn_valid_o=0, up_ready_o=1, no flushed value ever appears.
REQ-036 rst_n_i pulsed low asynchronously between clock edges with an entry held -> dn_valid_o=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register stage with overflow trap capture and valid/ready flow control.
// Define EX_MEM_SKID_EN for a two-entry head+skid buffer with a registered up_ready_o.
module ex_mem_stage #(
    parameter int unsigned DAT_WIDTH  = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  up_valid_i,
    output logic                  up_ready_o,
    input  logic [DAT_WIDTH-1:0]  alu_out_i,
    input  logic                  alu_of_i,
    input  logic                  ovf_chk_i,
    input  logic                  wr_en_i,
    input  logic [REG_ADDR_W-1:0] wr_addr_i,
    input  logic [1:0]            mem_op_i,
    input  logic [DAT_WIDTH-1:0]  store_dat_i,
    input  logic [DAT_WIDTH-1:0]  pc_i,
    output logic                  dn_valid_o,
    input  logic                  dn_ready_i,
    output logic [DAT_WIDTH-1:0]  alu_out_o,
    output logic [DAT_WIDTH-1:0]  store_dat_o,
    output logic [DAT_WIDTH-1:0]  pc_o,
    output logic                  wr_en_o,
    output logic [REG_ADDR_W-1:0] wr_addr_o,
    output logic [1:0]            mem_op_o,
    output logic                  exc_o,
    output logic [DAT_WIDTH-1:0]  exc_pc_o
);

    typedef struct packed {
        logic [DAT_WIDTH-1:0]  alu;
        logic [DAT_WIDTH-1:0]  sdat;
        logic [DAT_WIDTH-1:0]  pc;
        logic                  wr_en;
        logic [REG_ADDR_W-1:0] wr_addr;
        logic [1:0]            mem_op;
        logic                  exc;
    } entry_t;

    logic   trap;
    logic   up_fire;
    logic   dn_fire;
    entry_t in_e;
    entry_t head_q, head_n;
    logic   head_v_q, head_v_n;

`ifdef EX_MEM_SKID_EN
    entry_t skid_q, skid_n;
    logic   skid_v_q, skid_v_n;
    logic   ready_q;

    assign up_ready_o = ready_q;
`else
    assign up_ready_o = !head_v_q || dn_ready_i;
`endif

    assign trap    = alu_of_i && ovf_chk_i;
    assign up_fire = up_valid_i && up_ready_o;
    assign dn_fire = head_v_q && dn_ready_i;

    // Trapping instructions must not write back or touch memory.
    always_comb begin
        in_e.alu     = alu_out_i;
        in_e.sdat    = store_dat_i;
        in_e.pc      = pc_i;
        in_e.wr_en   = wr_en_i && !trap;
        in_e.wr_addr = wr_addr_i;
        in_e.mem_op  = (trap || mem_op_i == 2'b11) ? 2'b00 : mem_op_i;
        in_e.exc     = trap;
    end

    always_comb begin
        head_n   = head_q;
        head_v_n = head_v_q;
`ifdef EX_MEM_SKID_EN
        skid_n   = skid_q;
        skid_v_n = skid_v_q;
        if (dn_fire) begin
            if (skid_v_q) begin
                head_n   = skid_q;
                skid_v_n = 1'b0;
            end else begin
                head_v_n = 1'b0;
            end
        end
        if (up_fire) begin
            if (!head_v_n) begin
                head_n   = in_e;
                head_v_n = 1'b1;
            end else begin
                skid_n   = in_e;
                skid_v_n = 1'b1;
            end
        end
        if (flush_i) begin
            head_v_n = 1'b0;
            skid_v_n = 1'b0;
        end
`else
        if (dn_fire) begin
            head_v_n = 1'b0;
        end
        if (up_fire) begin
            head_n   = in_e;
            head_v_n = 1'b1;
        end
        if (flush_i) begin
            head_v_n = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q   <= '0;
            head_v_q <= 1'b0;
            exc_o    <= 1'b0;
            exc_pc_o <= '0;
`ifdef EX_MEM_SKID_EN
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b1;
`endif
        end else begin
            head_q   <= head_n;
            head_v_q <= head_v_n;
            // The exception pulse follows the transfer even when a flush lands the same cycle.
            exc_o    <= dn_fire && head_q.exc;
            if (dn_fire && head_q.exc) begin
                exc_pc_o <= head_q.pc;
            end
`ifdef EX_MEM_SKID_EN
            skid_q   <= skid_n;
            skid_v_q <= skid_v_n;
            ready_q  <= !skid_v_n;
`endif
        end
    end

    assign dn_valid_o  = head_v_q;
    assign alu_out_o   = head_q.alu;
    assign store_dat_o = head_q.sdat;
    assign pc_o        = head_q.pc;
    assign wr_en_o     = head_q.wr_en;
    assign wr_addr_o   = head_q.wr_addr;
    assign mem_op_o    = head_q.mem_op;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_ex_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        up_valid_i;
    logic        up_ready_o;
    logic [31:0] alu_out_i;
    logic        alu_of_i;
    logic        ovf_chk_i;
    logic        wr_en_i;
    logic [4:0]  wr_addr_i;
    logic [1:0]  mem_op_i;
    logic [31:0] store_dat_i;
    logic [31:0] pc_i;
    logic        dn_valid_o;
    logic        dn_ready_i;
    logic [31:0] alu_out_o;
    logic [31:0] store_dat_o;
    logic [31:0] pc_o;
    logic        wr_en_o;
    logic [4:0]  wr_addr_o;
    logic [1:0]  mem_op_o;
    logic        exc_o;
    logic [31:0] exc_pc_o;

    ex_mem_stage #(.DAT_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .up_valid_i(up_valid_i), .up_ready_o(up_ready_o),
        .alu_out_i(alu_out_i), .alu_of_i(alu_of_i), .ovf_chk_i(ovf_chk_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .mem_op_i(mem_op_i),
        .store_dat_i(store_dat_i), .pc_i(pc_i),
        .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready_i),
        .alu_out_o(alu_out_o), .store_dat_o(store_dat_o), .pc_o(pc_o),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .mem_op_o(mem_op_o),
        .exc_o(exc_o), .exc_pc_o(exc_pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] pc;
        logic        of;
        logic        chk;
        logic        wr_en;
        logic [4:0]  addr;
        logic [1:0]  mop;
    } in_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] pc;
        logic        wr_en;
        logic [4:0]  addr;
        logic [1:0]  mop;
        logic        exc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic        exc_due = 1'b0;
    logic [31:0] exp_exc_pc = '0;

`ifdef EX_MEM_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk_in(logic [31:0] alu, logic of, logic chk, logic we,
                                  logic [4:0] addr, logic [1:0] mop, logic [31:0] sd, logic [31:0] pc);
        in_t v;
        v.alu = alu; v.of = of; v.chk = chk; v.wr_en = we;
        v.addr = addr; v.mop = mop; v.sd = sd; v.pc = pc;
        return v;
    endfunction

    function automatic exp_t mk_exp(logic [31:0] alu, logic we, logic [4:0] addr,
                                    logic [1:0] mop, logic [31:0] sd, logic [31:0] pc, logic exc);
        exp_t e;
        e.alu = alu; e.wr_en = we; e.addr = addr; e.mop = mop;
        e.sd = sd; e.pc = pc; e.exc = exc;
        return e;
    endfunction

    task automatic drive(input in_t v);
        up_valid_i  = 1'b1;
        alu_out_i   = v.alu;
        alu_of_i    = v.of;
        ovf_chk_i   = v.chk;
        wr_en_i     = v.wr_en;
        wr_addr_i   = v.addr;
        mem_op_i    = v.mop;
        store_dat_i = v.sd;
        pc_i        = v.pc;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one entry for one cycle; the expectation is queued only if the stage takes it.
    task automatic send(input in_t v, input exp_t e, input logic exp_rdy);
        drive(v);
        @(negedge clk_i);
        check("up_ready", {63'd0, up_ready_o}, {63'd0, exp_rdy});
        if (up_ready_o && !flush_i) sb.push_back(e);
        step();
        up_valid_i = 1'b0;
    endtask

    initial begin : monitor
        exp_t f;
        logic nxt_due;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                sb.delete();
                exc_due    = 1'b0;
                exp_exc_pc = '0;
            end else begin
                check("exc_o", {63'd0, exc_o}, {63'd0, exc_due});
                check("exc_pc", {32'd0, exc_pc_o}, {32'd0, exp_exc_pc});
                nxt_due = 1'b0;
                if (dn_valid_o) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", {63'd0, dn_valid_o}, 64'd0);
                    end else begin
                        f = sb[0];
                        check("alu_out", {32'd0, alu_out_o}, {32'd0, f.alu});
                        check("store_dat", {32'd0, store_dat_o}, {32'd0, f.sd});
                        check("pc", {32'd0, pc_o}, {32'd0, f.pc});
                        check("wr_en/addr/mop", {56'd0, wr_en_o, wr_addr_o, mem_op_o},
                              {56'd0, f.wr_en, f.addr, f.mop});
                        if (dn_ready_i) begin
                            if (f.exc) begin
                                nxt_due    = 1'b1;
                                exp_exc_pc = f.pc;
                            end
                            void'(sb.pop_front());
                        end
                    end
                end
                exc_due = nxt_due;
                if (flush_i) sb.delete();
            end
        end
    end

    initial begin : stim
        int vals[3];
        int idx;
        logic exp_rdy_tab[4];
        vals = '{1, 2, 3};

        rst_n_i = 1'b0; flush_i = 1'b0; up_valid_i = 1'b0; dn_ready_i = 1'b1;
        drive(mk_in(32'h0, 0, 0, 0, 5'd0, 2'b00, 32'h0, 32'h0));
        up_valid_i = 1'b0;

        repeat (2) @(negedge clk_i);
        check("rst_dn_valid", {63'd0, dn_valid_o}, 64'd0);
        check("rst_exc", {63'd0, exc_o}, 64'd0);
        check("rst_ctl", {56'd0, wr_en_o, wr_addr_o, mem_op_o}, 64'd0);
        check("rst_data", {alu_out_o, pc_o}, 64'd0);
        check("rst_sd_excpc", {store_dat_o, exc_pc_o}, 64'd0);
        @(posedge clk_i); #2 rst_n_i = 1'b1;
        @(negedge clk_i);
        check("ready_after_rst", {63'd0, up_ready_o}, 64'd1);
        step();

        // basic single transfer with one-cycle latency
        send(mk_in(32'h5, 0, 0, 1, 5'd3, 2'b00, 32'h0, 32'h0),
             mk_exp(32'h5, 1, 5'd3, 2'b00, 32'h0, 32'h0, 0), 1'b1);
        @(negedge clk_i);
        check("lat_valid", {63'd0, dn_valid_o}, 64'd1);
        check("lat_data", {27'd0, wr_addr_o, alu_out_o}, {27'd0, 5'd3, 32'h5});
        @(negedge clk_i);
        check("lat_empty", {63'd0, dn_valid_o}, 64'd0);
        step();

        // signed overflow traps: writeback and memory op suppressed
        send(mk_in(32'h8000_0000, 1, 1, 1, 5'd7, 2'b01, 32'hAA, 32'h100),
             mk_exp(32'h8000_0000, 0, 5'd7, 2'b00, 32'hAA, 32'h100, 1), 1'b1);
        @(negedge clk_i);
        @(negedge clk_i);
        check("trap_exc", {63'd0, exc_o}, 64'd1);
        check("trap_pc", {32'd0, exc_pc_o}, 64'h100);
        @(negedge clk_i);
        check("trap_pulse_end", {63'd0, exc_o}, 64'd0);
        step();

        // back-to-back: unsigned overflow ignored, reserved op, check without overflow
        send(mk_in(32'hFFFF_0001, 1, 0, 1, 5'd9, 2'b10, 32'h1234, 32'h104),
             mk_exp(32'hFFFF_0001, 1, 5'd9, 2'b10, 32'h1234, 32'h104, 0), 1'b1);
        send(mk_in(32'h11, 0, 0, 0, 5'd10, 2'b11, 32'h55, 32'h108),
             mk_exp(32'h11, 0, 5'd10, 2'b00, 32'h55, 32'h108, 0), 1'b1);
        send(mk_in(32'h22, 0, 1, 1, 5'd31, 2'b01, 32'h66, 32'h10C),
             mk_exp(32'h22, 1, 5'd31, 2'b01, 32'h66, 32'h10C, 0), 1'b1);
        repeat (3) step();

        // downstream stall with continuous offers 1,2,3
        exp_rdy_tab = SKID ? '{1'b1, 1'b1, 1'b0, 1'b0} : '{1'b1, 1'b0, 1'b0, 1'b0};
        dn_ready_i = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive(mk_in(vals[idx], 0, 0, 1, 5'(vals[idx]), 2'b00, 32'h0, 32'h200 + 32'(vals[idx])));
            @(negedge clk_i);
            check("stall_ready", {63'd0, up_ready_o}, {63'd0, exp_rdy_tab[c]});
            if (up_ready_o) begin
                sb.push_back(mk_exp(vals[idx], 1, 5'(vals[idx]), 2'b00, 32'h0, 32'h200 + 32'(vals[idx]), 0));
                if (idx < 2) idx++;
            end
            step();
        end
        up_valid_i = 1'b0;
        check("stall_accepted", 64'(idx), SKID ? 64'd2 : 64'd1);
        check("stall_hold", {31'd0, dn_valid_o, alu_out_o}, {31'd0, 1'b1, 32'h1});
        dn_ready_i = 1'b1;
        repeat (4) step();

        // flush with entries held and a same-cycle upstream offer
        dn_ready_i = 1'b0;
        send(mk_in(32'hA1, 0, 0, 1, 5'd1, 2'b00, 32'h0, 32'h400),
             mk_exp(32'hA1, 1, 5'd1, 2'b00, 32'h0, 32'h400, 0), 1'b1);
        send(mk_in(32'hA2, 0, 0, 1, 5'd2, 2'b00, 32'h0, 32'h404),
             mk_exp(32'hA2, 1, 5'd2, 2'b00, 32'h0, 32'h404, 0), SKID);
        flush_i = 1'b1;
        drive(mk_in(32'hA3, 0, 0, 1, 5'd3, 2'b00, 32'h0, 32'h408));
        step();
        flush_i = 1'b0; up_valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_valid", {63'd0, dn_valid_o}, 64'd0);
        check("flush_ready", {63'd0, up_ready_o}, 64'd1);
        dn_ready_i = 1'b1;
        repeat (4) step();

        // flush coinciding with downstream transfer of a trapping entry
        dn_ready_i = 1'b0;
        send(mk_in(32'hB0, 1, 1, 1, 5'd4, 2'b10, 32'h77, 32'h300),
             mk_exp(32'hB0, 0, 5'd4, 2'b00, 32'h77, 32'h300, 1), 1'b1);
        flush_i = 1'b1; dn_ready_i = 1'b1;
        drive(mk_in(32'hB1, 0, 0, 1, 5'd5, 2'b00, 32'h0, 32'h304));
        step();
        flush_i = 1'b0; up_valid_i = 1'b0; dn_ready_i = 1'b0;
        @(negedge clk_i);
        check("flush_exc", {31'd0, exc_o, exc_pc_o}, {31'd0, 1'b1, 32'h300});
        check("flush_exc_valid", {63'd0, dn_valid_o}, 64'd0);
        dn_ready_i = 1'b1;
        repeat (3) step();

        // asynchronous reset mid-cycle with an entry held
        dn_ready_i = 1'b0;
        send(mk_in(32'hC0, 0, 0, 1, 5'd6, 2'b01, 32'h99, 32'h500),
             mk_exp(32'hC0, 1, 5'd6, 2'b01, 32'h99, 32'h500, 0), 1'b1);
        #2 rst_n_i = 1'b0;
        #1;
        check("arst_valid", {63'd0, dn_valid_o}, 64'd0);
        check("arst_ctl", {55'd0, exc_o, wr_en_o, wr_addr_o, mem_op_o}, 64'd0);
        check("arst_data", {alu_out_o, pc_o}, 64'd0);
        check("arst_sd_excpc", {store_dat_o, exc_pc_o}, 64'd0);
        @(posedge clk_i); #2 rst_n_i = 1'b1;
        @(negedge clk_i);
        check("arst_ready", {62'd0, up_ready_o, dn_valid_o}, 64'd2);
        dn_ready_i = 1'b1;
        step();
        send(mk_in(32'hD0, 0, 0, 1, 5'd8, 2'b10, 32'hEE, 32'h600),
             mk_exp(32'hD0, 1, 5'd8, 2'b10, 32'hEE, 32'h600, 0), 1'b1);
        repeat (3) step();

        check("drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
